// File: rtl/eproc_in_comma_align_if.sv
// rtl/eproc_in_comma_align_if.sv - E-link serial input and aligned 10b symbol output bundle
interface eproc_in_comma_align_if #(
  parameter int IN_WIDTH = 2
);
  logic [IN_WIDTH-1:0] DATA_IN;
  logic                swap_inputbits;
  logic                REVERSE_10B;
  logic [9:0]          DATA_OUT;
  logic                DATA_RDY;
  logic                IS_COMMA;
  logic                ALIGNED;
  logic [7:0]          ALIGN_ERR_CNT;

  // master drives the serial link and consumes symbols; slave is the aligner
  modport master (
    output DATA_IN, swap_inputbits, REVERSE_10B,
    input  DATA_OUT, DATA_RDY, IS_COMMA, ALIGNED, ALIGN_ERR_CNT
  );

  modport slave (
    input  DATA_IN, swap_inputbits, REVERSE_10B,
    output DATA_OUT, DATA_RDY, IS_COMMA, ALIGNED, ALIGN_ERR_CNT
  );
endinterface

// File: rtl/eproc_in_comma_align.sv
// rtl/eproc_in_comma_align.sv - E-link deserialiser with K28.5 comma alignment and lock FSM
// Define EPROC_IN_ALIGN_STATS_EN to enable the saturating ALIGN_ERR_CNT statistics counter.
module eproc_in_comma_align #(
  parameter int IN_WIDTH   = 2,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_ERR    = 3
) (
  input  logic                  bitCLK,
  input  logic                  rst,
  eproc_in_comma_align_if.slave link
);
  localparam int         SW        = IN_WIDTH + 9;
  localparam logic [9:0] K285_NEG  = 10'b0011111010;
  localparam logic [9:0] K285_POS  = 10'b1100000101;
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] ERR_LAST  = 4'(MAX_ERR - 1);
  localparam logic [4:0] IN_W5     = 5'(IN_WIDTH);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t        state;
  logic [SW-1:0] sreg;
  logic [3:0]    avail, good_cnt, err_cnt;
  logic [9:0]    data_out_q;
  logic          data_rdy_q, is_comma_q, aligned_q;

  logic [IN_WIDTH-1:0] din, comma_hit, end_mask;
  logic [4:0]          a_sum;
  logic                emit, hunt_hit, word_is_comma, misaligned, aligned_hit;
  logic [3:0]          e_pos, next_avail, hunt_p;
  logic [9:0]          word, hunt_word;

  function automatic logic [9:0] fmt(input logic [9:0] w, input logic rev);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = w[9-i];
    return rev ? r : w;
  endfunction

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++)
      din[i] = link.swap_inputbits ? link.DATA_IN[IN_WIDTH-1-i] : link.DATA_IN[i];
  end

  // sreg holds the bits shifted in on the previous edge; window p ends at sreg[p]
  always_comb begin
    a_sum      = {1'b0, avail} + IN_W5;
    emit       = (a_sum >= 5'd10);
    e_pos      = emit ? 4'(a_sum - 5'd10) : 4'd0;
    next_avail = emit ? e_pos : a_sum[3:0];
    comma_hit  = '0;
    end_mask   = '0;
    word       = '0;
    hunt_hit   = 1'b0;
    hunt_p     = '0;
    hunt_word  = '0;
    for (int p = 0; p < IN_WIDTH; p++) begin
      comma_hit[p] = (sreg[p+:10] == K285_NEG) || (sreg[p+:10] == K285_POS);
      end_mask[p]  = emit && (e_pos == 4'(p));
      if (end_mask[p]) word = sreg[p+:10];
    end
    // lowest p is the most recent comma, so it wins the search
    for (int p = IN_WIDTH - 1; p >= 0; p--) begin
      if (comma_hit[p]) begin
        hunt_hit  = 1'b1;
        hunt_p    = 4'(p);
        hunt_word = sreg[p+:10];
      end
    end
    word_is_comma = |(comma_hit & end_mask);
    misaligned    = |(comma_hit & ~end_mask);
    aligned_hit   = word_is_comma && !misaligned;
  end

  always_ff @(posedge bitCLK) begin
    if (rst) begin
      state      <= HUNT;
      sreg       <= '0;
      avail      <= '0;
      good_cnt   <= '0;
      err_cnt    <= '0;
      data_out_q <= '0;
      data_rdy_q <= 1'b0;
      is_comma_q <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      sreg       <= {sreg[8:0], din};
      data_rdy_q <= 1'b0;
      is_comma_q <= 1'b0;
      case (state)
        HUNT: begin
          if (hunt_hit) begin
            data_out_q <= fmt(hunt_word, link.REVERSE_10B);
            data_rdy_q <= 1'b1;
            is_comma_q <= 1'b1;
            avail      <= hunt_p;
            good_cnt   <= 4'd1;
            if (LOCK_COUNT == 1) begin
              state     <= LOCKED;
              aligned_q <= 1'b1;
              err_cnt   <= '0;
            end else begin
              state <= SYNC;
            end
          end
        end
        SYNC: begin
          if (misaligned) begin
            state <= HUNT;
          end else begin
            avail <= next_avail;
            if (emit) begin
              data_out_q <= fmt(word, link.REVERSE_10B);
              data_rdy_q <= 1'b1;
              is_comma_q <= word_is_comma;
            end
            if (aligned_hit) begin
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt == LOCK_LAST) begin
                state     <= LOCKED;
                aligned_q <= 1'b1;
                err_cnt   <= '0;
              end
            end
          end
        end
        LOCKED: begin
          avail <= next_avail;
          if (emit) begin
            data_out_q <= fmt(word, link.REVERSE_10B);
            data_rdy_q <= 1'b1;
            is_comma_q <= word_is_comma;
          end
          if (misaligned) begin
            err_cnt <= err_cnt + 4'd1;
            if (err_cnt == ERR_LAST) begin
              state     <= HUNT;
              aligned_q <= 1'b0;
            end
          end else if (aligned_hit) begin
            err_cnt <= '0;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef EPROC_IN_ALIGN_STATS_EN
  logic [7:0] stat_cnt;
  always_ff @(posedge bitCLK) begin
    if (rst) stat_cnt <= '0;
    else if ((state != HUNT) && misaligned && (stat_cnt != 8'hFF)) stat_cnt <= stat_cnt + 8'd1;
  end
  assign link.ALIGN_ERR_CNT = stat_cnt;
`else
  assign link.ALIGN_ERR_CNT = 8'd0;
`endif

  assign link.DATA_OUT = data_out_q;
  assign link.DATA_RDY = data_rdy_q;
  assign link.IS_COMMA = is_comma_q;
  assign link.ALIGNED  = aligned_q;
endmodule

// File: tb/tb_eproc_in_comma_align.sv
// tb/tb_eproc_in_comma_align.sv - bit-serial reference model bench for eproc_in_comma_align at 2/4/8 bits
module tb_eproc_in_comma_align;
  localparam int         LOCK = 4;
  localparam int         MAXE = 3;
  localparam logic [9:0] KN   = 10'b0011111010;
  localparam logic [9:0] KP   = 10'b1100000101;
  localparam logic [9:0] D215 = 10'b1010101010;
`ifdef EPROC_IN_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eproc_in_comma_align_if #(.IN_WIDTH(2)) if2 ();
  eproc_in_comma_align_if #(.IN_WIDTH(4)) if4 ();
  eproc_in_comma_align_if #(.IN_WIDTH(8)) if8 ();

  eproc_in_comma_align #(.IN_WIDTH(2), .LOCK_COUNT(LOCK), .MAX_ERR(MAXE)) u2 (.bitCLK(clk), .rst(rst), .link(if2));
  eproc_in_comma_align #(.IN_WIDTH(4), .LOCK_COUNT(LOCK), .MAX_ERR(MAXE)) u4 (.bitCLK(clk), .rst(rst), .link(if4));
  eproc_in_comma_align #(.IN_WIDTH(8), .LOCK_COUNT(LOCK), .MAX_ERR(MAXE)) u8 (.bitCLK(clk), .rst(rst), .link(if8));

  int  checks = 0;
  int  failures = 0;
  bit  started = 1'b0;
  int  act = 0;
  bit  sq[$];
  bit  sw[3];
  bit  rv[3];
  logic [7:0] prv[3];

  // model state: positions are absolute bit indices in arrival order
  int         mst[3], mgood[3], merr[3], mstat[3];
  longint     mbits[3], mnend[3];
  logic [9:0] mh[3];
  logic [9:0] x_out[3];
  logic       x_rdy[3], x_isc[3], x_al[3];

  task automatic chk(input string nm, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, actual, expected);
    end
  endtask

  function automatic bit is_k(input logic [9:0] w);
    return (w == KN) || (w == KP);
  endfunction

  function automatic logic [9:0] shown(input logic [9:0] w, input bit r);
    logic [9:0] o;
    for (int i = 0; i < 10; i++) o[i] = r ? w[9-i] : w[i];
    return o;
  endfunction

  function automatic logic [7:0] enc(input logic [7:0] g, input int w, input bit s);
    logic [7:0] d;
    d = g;
    if (s) for (int i = 0; i < w; i++) d[i] = g[w-1-i];
    return d;
  endfunction

  task automatic mreset(input int k);
    mst[k] = 0; mgood[k] = 0; merr[k] = 0; mstat[k] = 0;
    mbits[k] = 0; mnend[k] = 0; mh[k] = '0;
    x_out[k] = '0; x_rdy[k] = 1'b0; x_isc[k] = 1'b0; x_al[k] = 1'b0;
  endtask

  task automatic mstep(input int k, input logic [7:0] g);
    int         w;
    bit         emit, ehit, mis, any, hit;
    logic [9:0] word, hw;
    longint     hidx, idx;
    w = 2 << k;
    emit = 0; ehit = 0; mis = 0; any = 0; word = '0; hw = '0; hidx = 0;
    for (int i = 0; i < w; i++) begin
      mh[k] = {mh[k][8:0], g[w-1-i]};
      idx = mbits[k];
      mbits[k]++;
      hit = is_k(mh[k]);
      if (mst[k] != 0 && idx == mnend[k]) begin
        emit = 1; word = mh[k]; ehit = hit;
      end else if (hit) begin
        mis = 1;
      end
      if (hit) begin any = 1; hw = mh[k]; hidx = idx; end
    end
    x_rdy[k] = 1'b0;
    x_isc[k] = 1'b0;
    case (mst[k])
      0: if (any) begin
        x_rdy[k] = 1'b1; x_out[k] = shown(hw, rv[k]); x_isc[k] = 1'b1;
        mnend[k] = hidx + 10; mgood[k] = 1;
        if (LOCK == 1) begin mst[k] = 2; merr[k] = 0; end else mst[k] = 1;
      end
      1: if (mis) begin
        if (mstat[k] < 255) mstat[k]++;
        mst[k] = 0;
      end else if (emit) begin
        x_rdy[k] = 1'b1; x_out[k] = shown(word, rv[k]); x_isc[k] = is_k(word);
        mnend[k] += 10;
        if (ehit) begin
          mgood[k]++;
          if (mgood[k] == LOCK) begin mst[k] = 2; merr[k] = 0; end
        end
      end
      default: begin
        if (emit) begin
          x_rdy[k] = 1'b1; x_out[k] = shown(word, rv[k]); x_isc[k] = is_k(word);
          mnend[k] += 10;
        end
        if (mis) begin
          if (mstat[k] < 255) mstat[k]++;
          merr[k]++;
          if (merr[k] == MAXE) mst[k] = 0;
        end else if (ehit) begin
          merr[k] = 0;
        end
      end
    endcase
    x_al[k] = (mst[k] == 2);
  endtask

  task automatic get(input int k, output logic [9:0] o, output logic r, output logic c,
                     output logic a, output logic [7:0] e);
    case (k)
      0: begin o = if2.DATA_OUT; r = if2.DATA_RDY; c = if2.IS_COMMA; a = if2.ALIGNED; e = if2.ALIGN_ERR_CNT; end
      1: begin o = if4.DATA_OUT; r = if4.DATA_RDY; c = if4.IS_COMMA; a = if4.ALIGNED; e = if4.ALIGN_ERR_CNT; end
      default: begin o = if8.DATA_OUT; r = if8.DATA_RDY; c = if8.IS_COMMA; a = if8.ALIGNED; e = if8.ALIGN_ERR_CNT; end
    endcase
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) sq.push_back(s[i]);
  endtask

  task automatic step();
    logic [7:0] g[3];
    logic [7:0] t;
    int         w;
    for (int k = 0; k < 3; k++) g[k] = '0;
    w = 2 << act;
    for (int i = 0; i < w; i++) if (sq.size() > 0) g[act][w-1-i] = sq.pop_front();
    t = enc(g[0], 2, sw[0]); if2.DATA_IN = t[1:0];
    t = enc(g[1], 4, sw[1]); if4.DATA_IN = t[3:0];
    t = enc(g[2], 8, sw[2]); if8.DATA_IN = t;
    if2.swap_inputbits = sw[0]; if4.swap_inputbits = sw[1]; if8.swap_inputbits = sw[2];
    if2.REVERSE_10B = rv[0]; if4.REVERSE_10B = rv[1]; if8.REVERSE_10B = rv[2];
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) mreset(k);
      else mstep(k, prv[k]);
      prv[k] = rst ? 8'h00 : g[k];
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic [9:0] o;
        logic       r, c, a;
        logic [7:0] e;
        get(k, o, r, c, a, e);
        chk($sformatf("u%0d_data_out", 2 << k), o, x_out[k]);
        chk($sformatf("u%0d_data_rdy", 2 << k), r, x_rdy[k]);
        chk($sformatf("u%0d_is_comma", 2 << k), c, x_isc[k]);
        chk($sformatf("u%0d_aligned", 2 << k), a, x_al[k]);
        chk($sformatf("u%0d_err_cnt", 2 << k), e, STATS ? mstat[k] : 0);
      end
    end
  end

  initial begin
    logic [9:0] o;
    logic       r, c, a;
    logic [7:0] e;
    int         first, last, rise, iv, piv, ncomma, rec;
    bit         saw_lock, saw_fall;
    for (int k = 0; k < 3; k++) begin sw[k] = 0; rv[k] = 0; prv[k] = '0; end
    rst = 1'b1;
    step();
    started = 1'b1;
    step();
    rst = 1'b0;
    get(2, o, r, c, a, e);
    chk("reset_data_out", o, 0);
    chk("reset_aligned", a, 0);

    // 2-bit link, RD- commas at bit offset 3
    act = 0;
    repeat (3) sq.push_back(1'b0);
    repeat (12) push_sym(KN);
    first = -1; last = -1; rise = -1;
    for (int n = 1; n <= 70; n++) begin
      step();
      get(0, o, r, c, a, e);
      if (r) begin
        if (first < 0) begin
          first = n;
          chk("w2_first_data", o, 10'h0FA);
          chk("w2_first_is_comma", c, 1);
        end else begin
          chk("w2_symbol_interval", n - last, 5);
        end
        last = n;
      end
      if (a && rise < 0) rise = n;
    end
    chk("w2_lock_delay", rise - first, 15);

    // 4-bit link, comma + 7x D21.5 frames
    act = 1;
    repeat (4) begin
      push_sym(KN);
      repeat (7) push_sym(D215);
    end
    last = -1; piv = -1; ncomma = 0;
    for (int n = 1; n <= 85; n++) begin
      step();
      get(1, o, r, c, a, e);
      if (r) begin
        if (c) ncomma++;
        if (last >= 0) begin
          iv = n - last;
          chk("w4_interval_2or3", (iv == 2 || iv == 3), 1);
          if (piv >= 0) chk("w4_interval_pair", iv + piv, 5);
          piv = iv;
        end
        last = n;
      end
    end
    chk("w4_comma_count", ncomma, 4);

    // 8-bit link: lock, then slip the stream by one bit
    act = 2;
    repeat (6) push_sym(KN);
    sq.push_back(1'b0);
    repeat (10) push_sym(KN);
    saw_lock = 0; saw_fall = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      get(2, o, r, c, a, e);
      if (a) saw_lock = 1;
      else if (saw_lock) saw_fall = 1;
    end
    chk("w8_unlock_on_slip", saw_fall, 1);
    chk("w8_relocked", a, 1);
    chk("w8_err_events", e, STATS ? 3 : 0);

    // reset mid-symbol while locked
    push_sym(KN);
    step();
    sq.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    get(2, o, r, c, a, e);
    chk("rst_data_out", o, 0);
    chk("rst_data_rdy", r, 0);
    chk("rst_is_comma", c, 0);
    chk("rst_aligned", a, 0);
    chk("rst_err_cnt", e, 0);
    repeat (4) push_sym(KN);
    ncomma = 0; rec = -1;
    for (int n = 1; n <= 16; n++) begin
      step();
      get(2, o, r, c, a, e);
      if (r && c) ncomma++;
      if (a && rec < 0) rec = ncomma;
    end
    chk("w8_relock_after_comma", rec, 4);

    // swapped input bits and reversed output on the 4-bit link
    act = 1;
    sw[1] = 1; rv[1] = 1;
    repeat (2) push_sym(KN);
    first = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      get(1, o, r, c, a, e);
      if (r && first < 0) begin
        first = n;
        chk("swap_rev_data", o, 10'h17C);
        chk("swap_rev_is_comma", c, 1);
      end
    end
    chk("swap_rev_seen", (first > 0), 1);

    // alternating acquire / misaligned commas to saturate the statistics counter
    act = 2;
    repeat (660) begin
      push_sym(KN);
      sq.push_back(1'b0);
    end
    repeat (915) step();
    get(2, o, r, c, a, e);
    chk("w8_stats_saturate", e, STATS ? 255 : 0);

    repeat (3) step();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eproc_in_comma_align.md
# eproc_in_comma_align

Parametrised E-link input front end. It deserialises an IN_WIDTH-bit-per-clock E-link stream into 10-bit 8b10b symbols. It finds word alignment from K28.5 commas, qualifies and holds lock with a three-state FSM, and hands aligned symbols to the downstream 8b10b decoder. It replaces the fixed 2-bit EPROC_IN alignment path and supports 2-, 4- and 8-bit E-links on one clock.

## Interface
- IN_WIDTH, 2, E-link bits per clock; legal values 2, 4, 8.
- LOCK_COUNT, 4, aligned commas needed in SYNC before entering LOCKED; range 1..15.
- MAX_ERR, 3, misaligned commas tolerated in LOCKED before returning to HUNT; range 1..15.
- bitCLK  in  1  E-link clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- DATA_IN  in  IN_WIDTH  serial bits. DATA_IN[IN_WIDTH-1] is the earliest bit in time.
- swap_inputbits  in  1  when 1, DATA_IN is bit-reversed before use.
- REVERSE_10B  in  1  when 1, DATA_OUT is bit-reversed. When 0, DATA_OUT[9] is the earliest bit ("a").
- DATA_OUT  out  10  aligned symbol; holds its value between DATA_RDY pulses.
- DATA_RDY  out  1  one-cycle strobe; DATA_OUT is valid.
- IS_COMMA  out  1  qualifies DATA_RDY; the symbol is K28.5 (0011111010 or 1100000101, a-first).
- ALIGNED  out  1  FSM is in LOCKED.
- ALIGN_ERR_CNT  out  8  saturating misaligned-comma count (see Configuration).

## Operation
- Shift register: sreg, width IN_WIDTH+9. Each cycle it shifts left by IN_WIDTH, and the new bits enter sreg[IN_WIDTH-1:0] with the earliest bit at the highest index.
- Candidate window p, for p in 0..IN_WIDTH-1: sreg[p+9:p] after the shift. Each bit position is examined exactly once as a window end. comma_hit[p] is set if the window equals either K28.5 pattern.
- Fill counter avail counts bits held since the last symbol; range 0..9.
- Each cycle compute a = avail + IN_WIDTH.
  - If a >= 10: emit the word sreg[a-1 -: 10] and set avail = a-10. The word's window end is e = a-10.
  - Otherwise set avail = a.
- A comma hit at p is aligned only if a word is emitted this cycle and p == e. Every other hit is misaligned.
- FSM states:
  - HUNT (reset state):
    - On any comma_hit, take the lowest p.
    - Emit sreg[p+9:p] as a symbol with IS_COMMA=1.
    - Set avail=p and good_cnt=1.
    - If LOCK_COUNT==1 go to LOCKED, else go to SYNC.
    - DATA_RDY fires for this comma only; no other output in HUNT.
  - SYNC:
    - Emit symbols normally.
    - An aligned comma increments good_cnt; at good_cnt==LOCK_COUNT go to LOCKED and clear err_cnt.
    - Any misaligned comma returns to HUNT; the same cycle's word is discarded.
  - LOCKED:
    - Emit symbols normally.
    - A misaligned comma increments err_cnt; an aligned comma clears it.
    - At err_cnt==MAX_ERR go to HUNT; that cycle's word is still emitted.
- Simultaneous aligned and misaligned hits in one cycle count as misaligned.
- Emitted symbols are DATA_RDY-strobed in every state; HUNT emits only the acquired comma.

## Timing
- Reset values: DATA_OUT=0, DATA_RDY=0, IS_COMMA=0, ALIGNED=0, ALIGN_ERR_CNT=0, sreg=0, avail=0, state=HUNT.
- Reset asserted mid-symbol discards all partial bits on the next edge.
- Latency: the symbol's last bit is sampled at edge N; DATA_RDY and DATA_OUT are registered at edge N+1.
- Symbol rate per clock is IN_WIDTH/10:
  - 2-bit: one symbol every 5 clocks.
  - 4-bit: 2- and 3-clock intervals alternating.
  - 8-bit: symbols on 4 of every 5 clocks, never 2 per clock.
- ALIGNED rises in the same cycle as the DATA_RDY of the LOCK_COUNT-th aligned comma. It falls in the cycle of the DATA_RDY of the MAX_ERR-th misaligned-comma event.
- No backpressure. The consumer must accept every DATA_RDY.

## Configuration
- EPROC_IN_ALIGN_STATS_EN defined:
  - ALIGN_ERR_CNT counts every misaligned-comma event in SYNC or LOCKED, saturating at 255.
  - It is cleared only by rst.
- EPROC_IN_ALIGN_STATS_EN undefined: ALIGN_ERR_CNT is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then IN_WIDTH=2 with continuous K28.5 RD- (0011111010) at bit offset 3 → first DATA_RDY is a comma. With LOCK_COUNT=4, ALIGNED rises on the 4th comma, 15 clocks after the first. DATA_OUT=0x0FA every 5 clocks.
- IN_WIDTH=4, stream of comma, then D21.5 (1010101010) ×7, repeated → symbol interval pattern 2,3,2,3. IS_COMMA is set only on the comma.
- IN_WIDTH=8 and locked; then shift the stream by 1 bit → err_cnt reaches 3 after 3 commas. ALIGNED falls, and the FSM re-acquires at the new offset and relocks after 4 commas.
- swap_inputbits=1 with bit-reversed input nibbles, and REVERSE_10B=1 → DATA_OUT=0x17C for the RD- comma.
- Assert rst for 1 cycle while LOCKED mid-symbol → all outputs 0 on the next edge. Relock needs a full HUNT→SYNC→LOCKED sequence.
- With EPROC_IN_ALIGN_STATS_EN defined, inject 300 misaligned commas while in SYNC/LOCKED → ALIGN_ERR_CNT=255. With the macro undefined → ALIGN_ERR_CNT=0.
